// File: rtl/stage_m_ls_if.sv
// Execute-to-memory stage bus: E-stage results and controls in, M-stage copies,
// formatted load data and debug store signals out.
interface stage_m_ls_if;
  logic        arm, StallM, FlushM;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic        PCSrcE, RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE, MemSizeE;
  logic        MemUnsignedE;
  logic [31:0] ALUResultM, PCPlus4M;
  logic [4:0]  RdM;
  logic        PCSrcM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ReadDataW;
  logic        MemBusy, MisalignM;
  logic [31:0] WriteData, DataAddr;
  logic        MemWrite;
  logic [3:0]  ByteEn;

  modport master (
    output arm, StallM, FlushM, ALUResultE, WriteDataE, PCPlus4E, RdE,
           PCSrcE, RegWriteE, MemWriteE, ResultSrcE, MemSizeE, MemUnsignedE,
    input  ALUResultM, PCPlus4M, RdM, PCSrcM, RegWriteM, ResultSrcM, ReadDataW,
           MemBusy, MisalignM, WriteData, DataAddr, MemWrite, ByteEn
  );
  modport slave (
    input  arm, StallM, FlushM, ALUResultE, WriteDataE, PCPlus4E, RdE,
           PCSrcE, RegWriteE, MemWriteE, ResultSrcE, MemSizeE, MemUnsignedE,
    output ALUResultM, PCPlus4M, RdM, PCSrcM, RegWriteM, ResultSrcM, ReadDataW,
           MemBusy, MisalignM, WriteData, DataAddr, MemWrite, ByteEn
  );
endinterface

// File: rtl/stage_m_ls.sv
// Memory stage: E/M register, byte-enabled data RAM, load/store lane formatting
// and a wait-state FSM that back-pressures upstream while a slow access finishes.
module stage_m_ls #(
  parameter int ADDR_W = 13,
  parameter int WAIT   = 0
) (
  input logic         clk,
  input logic         rst,
  stage_m_ls_if.slave bus
);
  typedef struct packed {
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic        pcsrc, regw, memw;
    logic [1:0]  rsrc, size;
    logic        uns;
  } mreg_t;

  typedef enum logic [1:0] {IDLE, WAITING, COMMIT} state_t;

  localparam logic [3:0] WAIT4 = 4'(WAIT);

  mreg_t             m;
  state_t            state;
  logic [2:0]        cnt;
  logic [31:0]       rdw;
  logic [31:0]       mem [2**ADDR_W];

  logic              access, misalign, busy, at_commit, commit, do_wr, do_rd, adv;
  logic [1:0]        a;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       wdata, rword, ldata;
  logic [3:0]        be;
  logic [7:0]        lb;
  logic [15:0]       lh;
  logic              sx;

  assign a      = m.alu[1:0];
  assign widx   = m.alu[ADDR_W+1:2];
  assign access = m.memw || (m.rsrc == 2'b01);

  always_comb begin
    misalign = 1'b0;
    unique case (m.size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = access && a[0];
      default: misalign = access && (a != 2'b00);
    endcase
  end

  // Busy depends only on M contents and FSM state, never on the E inputs.
  always_comb begin
    busy      = 1'b0;
    at_commit = 1'b0;
    unique case (state)
      IDLE: begin
        busy      = access && (WAIT4 != 4'd0);
        at_commit = access && (WAIT4 == 4'd0);
      end
      WAITING: busy      = ({1'b0, cnt} <= WAIT4);
      COMMIT:  at_commit = 1'b1;
      default: ;
    endcase
  end

  assign commit = at_commit && !bus.StallM;
  assign do_wr  = commit && m.memw && !misalign && !rst;
  assign do_rd  = commit && (m.rsrc == 2'b01);
  assign adv    = !bus.StallM && !busy;

  always_comb begin
    wdata = m.wd;
    be    = 4'b1111;
    unique case (m.size)
      2'b00: begin
        wdata = {4{m.wd[7:0]}};
        be    = 4'b0001 << a;
      end
      2'b01: begin
        wdata = {2{m.wd[15:0]}};
        be    = a[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // ARM loads are always zero-extended regardless of MemUnsigned.
  always_comb begin
    rword = mem[widx];
    lb    = rword[{a, 3'b000} +: 8];
    lh    = a[1] ? rword[31:16] : rword[15:0];
    sx    = !m.uns && !bus.arm;
    unique case (m.size)
      2'b00:   ldata = {{24{sx & lb[7]}}, lb};
      2'b01:   ldata = {{16{sx & lh[15]}}, lh};
      default: ldata = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) m <= '0;
    else if (adv) begin
      if (bus.FlushM) m <= '0;
      else m <= '{alu: bus.ALUResultE, wd: bus.WriteDataE, pc4: bus.PCPlus4E,
                  rd: bus.RdE, pcsrc: bus.PCSrcE, regw: bus.RegWriteE,
                  memw: bus.MemWriteE, rsrc: bus.ResultSrcE, size: bus.MemSizeE,
                  uns: bus.MemUnsignedE};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rdw   <= '0;
    end else if (!bus.StallM) begin
      if (do_rd) rdw <= misalign ? 32'h0 : ldata;
      unique case (state)
        IDLE:
          if (access && (WAIT4 != 4'd0)) begin
            cnt   <= 3'd1;
            state <= (WAIT4 == 4'd1) ? COMMIT : WAITING;
          end
        WAITING: begin
          cnt <= cnt + 3'd1;
          if (({1'b0, cnt} + 4'd1) == WAIT4) state <= COMMIT;
        end
        COMMIT: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (do_wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign bus.ALUResultM = m.alu;
  assign bus.PCPlus4M   = m.pc4;
  assign bus.RdM        = m.rd;
  assign bus.PCSrcM     = m.pcsrc;
  assign bus.RegWriteM  = m.regw;
  assign bus.ResultSrcM = m.rsrc;
  assign bus.ReadDataW  = rdw;
  assign bus.MemBusy    = busy;
  assign bus.MisalignM  = misalign;
  assign bus.WriteData  = wdata;
  assign bus.DataAddr   = m.alu;
  assign bus.MemWrite   = do_wr;
  assign bus.ByteEn     = do_wr ? be : 4'b0000;
endmodule
